// File: rtl/ula_sequencer.sv
// Initiator side of the ULA interface: accepts NRISC register-register instructions,
// issues operands to an external clocked ULA and writes the result back to a 4-entry register file.
module ula_sequencer #(
    parameter int WIDTH     = 8,
    parameter bit REG0_ZERO = 1'b1
) (
    input  logic             c,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [1:0]       ula_op,
    input  logic [WIDTH-1:0] ula_result,
    input  logic             ula_zero,
    output logic             done,
    output logic             zero_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] regs [4];
    logic [1:0]       rd_q;

    logic [1:0]       op_in, rd_in, rs_in, rt_in;
    logic             ext_wr;
    logic [WIDTH-1:0] opnd_a, opnd_b;

    assign op_in = instr[7:6];
    assign rd_in = instr[5:4];
    assign rs_in = instr[3:2];
    assign rt_in = instr[1:0];

    assign ext_wr      = wr_en && (state == IDLE);
    assign instr_ready = (state == IDLE);
    assign done        = (state == DONE);

    // Operands forward a same-cycle external write so the instruction sees the new value
    always_comb begin
        opnd_a = regs[rs_in];
        opnd_b = regs[rt_in];
        if (ext_wr && (wr_addr == rs_in)) opnd_a = wr_data;
        if (ext_wr && (wr_addr == rt_in)) opnd_b = wr_data;
        if (REG0_ZERO && (rs_in == 2'd0)) opnd_a = '0;
        if (REG0_ZERO && (rt_in == 2'd0)) opnd_b = '0;
    end

    always_comb begin
        dbg_data = regs[dbg_addr];
        if (REG0_ZERO && (dbg_addr == 2'd0)) dbg_data = '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers only load on accept and otherwise hold their last values
    always_ff @(posedge c) begin
        if (rst) begin
            ula_a <= '0;
            ula_b <= '0;
            ula_op <= 2'b00;
            rd_q <= 2'd0;
        end else if ((state == IDLE) && instr_valid) begin
            ula_a <= opnd_a;
            ula_b <= opnd_b;
            ula_op <= op_in;
            rd_q <= rd_in;
        end
    end

    // External writes occur only in IDLE and writeback only in WAIT, so they never collide
    always_ff @(posedge c) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (ext_wr && !(REG0_ZERO && (wr_addr == 2'd0))) begin
                regs[wr_addr] <= wr_data;
            end
            if (state == WAIT) begin
                if (!(REG0_ZERO && (rd_q == 2'd0))) regs[rd_q] <= ula_result;
                zero_flag <= ula_zero;
            end
        end
    end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
Initiator side of the ULA interface. It accepts 8-bit NRISC register-register instructions over a valid/ready handshake and holds a 4-entry register file. For each instruction it drives operands and ULAOp to the ULA, waits for the ULA's clocked result, then writes the result and zero flag back. One instruction is in flight at a time, in a fixed 3-cycle sequence.

Parameters:
WIDTH, 8, data width of registers and ULA operands/result
REG0_ZERO, 1, when 1 R0 reads as 0 and writes to R0 are discarded

Ports:
c  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
instr_valid  input  1  upstream presents instruction
instr_ready  output  1  block can accept an instruction (IDLE only)
instr  input  8  [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt
wr_en  input  1  external register write (initialisation)
wr_addr  input  2  external write address
wr_data  input  WIDTH  external write data
dbg_addr  input  2  debug read address
dbg_data  output  WIDTH  combinational read of R[dbg_addr]
ula_a  output  WIDTH  left operand to ULA (registered)
ula_b  output  WIDTH  right operand to ULA (registered)
ula_op  output  2  ULAOp to ULA (registered)
ula_result  input  WIDTH  ULA result, updated by ULA on posedge c
ula_zero  input  1  ULA zero flag (result==0)
done  output  1  one-cycle pulse, writeback completed
zero_flag  output  1  sticky copy of ula_zero from last writeback

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; R0..R3=0; ula_a=ula_b=0; ula_op=2'b00; done=0; zero_flag=0. Reset mid-operation aborts the instruction with no writeback and no done.
- Op encoding, passed unchanged to ula_op: 00 add, 01 sub (rs-rt), 10 and, 11 or. Arithmetic wraps mod 2^WIDTH and no carry is kept.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: instr_ready=1. If instr_valid, latch instr and go to ISSUE. Otherwise stay.
- ISSUE: ula_a=R[rs], ula_b=R[rt], ula_op=op are registered on entry to ISSUE. They are read from register contents at the end of the IDLE cycle, including any same-cycle external write. Operands are stable for the whole ISSUE cycle, and the ULA samples them at the closing edge. Next state is WAIT.
- WAIT: ula_result/ula_zero are valid. At the closing edge, R[rd]<=ula_result and zero_flag<=ula_zero. Next state is DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE.
- Latency: accept edge to done high is 3 cycles. Maximum throughput is 1 instruction per 4 cycles.
- ula_a/ula_b/ula_op hold their last values outside ISSUE. They are not cleared.
- instr_ready=0 in ISSUE/WAIT/DONE. instr_valid in those states is ignored and not queued; upstream must hold it.
- External write: honoured only in IDLE. It is ignored in all other states, with no stall and no error.
- External write and instruction accept in the same IDLE cycle: both happen. The instruction's operands see the newly written value.
- REG0_ZERO=1: writeback or external write to R0 is discarded, and R0 reads 0 on operands and dbg_data. zero_flag still updates from ula_zero.
- rd equal to rs or rt: operands are captured before writeback, so the old value is used. Example: R1=R1+R1 doubles R1.
- dbg_data: combinational. It reflects a writeback from the cycle after the WAIT closing edge, i.e. during DONE.

Test Plan:
- Reset, R1=5, R2=3 via wr_en; instr add rd=3 rs=1 rt=2 -> ula_a=5, ula_b=3, ula_op=00 during ISSUE; done pulses 3 cycles after accept; R3=8; zero_flag=0.
- Sub rd=3 rs=2 rt=1 with R1=5, R2=3 -> R3=0xFE, zero_flag=0. Then sub rd=2 rs=1 rt=1 -> R2=0, zero_flag=1.
- And/or: R1=0xF0, R2=0x3C -> and gives 0x30, or gives 0xFC. Hold instr_valid high through busy cycles -> second instruction is accepted only after DONE, with exactly 4 cycles between accepts.
- R0 handling: wr_en to R0 with 0x55, then add rd=0 rs=1 rt=0 -> dbg R0=0, ula_b=0, done still pulses. Add rd=1 rs=1 rt=1 with R1=7 -> R1=14.
- Same-cycle wr_en R2=9 and accept of add rd=3 rs=2 rt=2 in IDLE -> ula_a=ula_b=9, R3=18. A wr_en issued during WAIT -> the target register is unchanged.
- Assert rst during WAIT of add rd=3 -> no done, R3=0, state IDLE, instr_ready=1 next cycle, ula outputs 0.
